// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares a single external reg_ALU between two requesters. An operation is
// accepted in IDLE (round-robin on ties), its operands are latched locally and
// then streamed to the ALU over one shared data bus:
//   IDLE -> LOAD_A -> LOAD_B -> LOAD_OP -> EXEC -> RESP -> IDLE
// The response is presented in RESP until the consumer accepts it.
//
// Optional feature (macro ALU_ARB_TIMEOUT_EN):
//   When defined, a response left unaccepted for 16 RESP cycles is dropped,
//   the FSM returns to IDLE and resp_dropped is set (sticky until reset).
//   When undefined, RESP waits forever and resp_dropped is tied low.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid/A/B/Op, reqN_ready   requester N operation and accept pulse
//   alu_data, alu_load_A/B/Op,      shared bus and strobes into reg_ALU
//   alu_update_Res
//   alu_Result, alu_Flags           reg_ALU outputs
//   resp_valid/id/Result/Flags,     response channel to the granted requester
//   resp_ready
//   busy                            FSM not in IDLE
//   resp_dropped                    sticky response-timeout indicator
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [1:0]       req0_Op,
    input  logic [1:0]       req1_Op,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_data,
    output logic             alu_load_A,
    output logic             alu_load_B,
    output logic             alu_load_Op,
    output logic             alu_update_Res,
    input  logic [WIDTH-1:0] alu_Result,
    input  logic [3:0]       alu_Flags,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_Result,
    output logic [3:0]       resp_Flags,
    input  logic             resp_ready,
    output logic             busy,
    output logic             resp_dropped
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        LOAD_OP = 3'd3,
        EXEC    = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               last_grant_r;
    logic               id_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [1:0]         op_r;
    logic               grant_en_s;
    logic               grant_id_s;
    logic               timeout_hit_s;

    // Round-robin pick: a lone requester always wins; on a tie the requester
    // that was not granted last wins.
    function automatic logic pick_winner(input logic v0, input logic v1,
                                         input logic last);
        logic w;
        if (v0 && v1) begin
            w = ~last;
        end else if (v1) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    // Grant decision; suppressed while reset is asserted so no accept pulse
    // can escape during reset.
    always_comb begin
        grant_en_s = 1'b0;
        grant_id_s = pick_winner(req0_valid, req1_valid, last_grant_r);
        if ((state_r == IDLE) && !reset) begin
            grant_en_s = req0_valid | req1_valid;
        end else begin
            grant_en_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; only IDLE and RESP have conditional exits.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_en_s) begin
                    state_s = LOAD_A;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_A:  state_s = LOAD_B;
            LOAD_B:  state_s = LOAD_OP;
            LOAD_OP: state_s = EXEC;
            EXEC:    state_s = RESP;
            RESP: begin
                if (resp_ready || timeout_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture at accept; later input changes cannot reach the
    // operation in flight. Pointer resets to 1 so requester 0 wins first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            op_r         <= 2'b00;
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (grant_en_s) begin
            a_r          <= grant_id_s ? req1_A  : req0_A;
            b_r          <= grant_id_s ? req1_B  : req0_B;
            op_r         <= grant_id_s ? req1_Op : req0_Op;
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt_r;
    logic       dropped_r;

    assign timeout_hit_s = (state_r == RESP) && !resp_ready && (wait_cnt_r == 4'd15);

    // Counts unaccepted RESP cycles; the 16th one drops the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
            dropped_r  <= 1'b0;
        end else if ((state_r == RESP) && !resp_ready) begin
            if (timeout_hit_s) begin
                wait_cnt_r <= 4'd0;
                dropped_r  <= 1'b1;
            end else begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    assign resp_dropped = dropped_r & ~reset;
`else
    assign timeout_hit_s = 1'b0;
    assign resp_dropped  = 1'b0;
`endif

    // Output decode from the state register; everything is forced low while
    // reset is asserted.
    always_comb begin
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        alu_data       = {WIDTH{1'b0}};
        alu_load_A     = 1'b0;
        alu_load_B     = 1'b0;
        alu_load_Op    = 1'b0;
        alu_update_Res = 1'b0;
        resp_valid     = 1'b0;
        resp_id        = 1'b0;
        resp_Result    = {WIDTH{1'b0}};
        resp_Flags     = 4'b0000;
        busy           = 1'b0;
        if (!reset) begin
            busy = (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    req0_ready = grant_en_s & ~grant_id_s;
                    req1_ready = grant_en_s &  grant_id_s;
                end
                LOAD_A: begin
                    alu_data   = a_r;
                    alu_load_A = 1'b1;
                end
                LOAD_B: begin
                    alu_data   = b_r;
                    alu_load_B = 1'b1;
                end
                LOAD_OP: begin
                    alu_data    = {{(WIDTH-2){1'b0}}, op_r};
                    alu_load_Op = 1'b1;
                end
                EXEC: begin
                    alu_update_Res = 1'b1;
                end
                RESP: begin
                    resp_valid  = 1'b1;
                    resp_id     = id_r;
                    resp_Result = alu_Result;
                    resp_Flags  = alu_Flags;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//
// Directed, table-driven bench for alu_rr_arbiter. Contains a small reg_ALU
// model (add/sub/and/or with {N,Z,C,V} flags) so the DUT has a real ALU to
// drive; expected results in the table are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [1:0]   req0_Op, req1_Op;
    logic         req0_ready, req1_ready;
    logic [W-1:0] alu_data;
    logic         alu_load_A, alu_load_B, alu_load_Op, alu_update_Res;
    logic [W-1:0] alu_Result;
    logic [3:0]   alu_Flags;
    logic         resp_valid, resp_id;
    logic [W-1:0] resp_Result;
    logic [3:0]   resp_Flags;
    logic         resp_ready;
    logic         busy, resp_dropped;

    int n_tests = 0;
    int n_fail  = 0;

    alu_rr_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
        .req0_Op(req0_Op), .req1_Op(req1_Op),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .alu_data(alu_data), .alu_load_A(alu_load_A), .alu_load_B(alu_load_B),
        .alu_load_Op(alu_load_Op), .alu_update_Res(alu_update_Res),
        .alu_Result(alu_Result), .alu_Flags(alu_Flags),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_Result(resp_Result), .resp_Flags(resp_Flags),
        .resp_ready(resp_ready), .busy(busy), .resp_dropped(resp_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reg_ALU model ----------------
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_op;

    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [1:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0; v = 1'b0; r = {W{1'b0}};
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'b01: begin
                r = a - b; c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {r[W-1], (r == {W{1'b0}}), c, v, r};
    endfunction

    always @(posedge clk) begin
        if (alu_load_A)  m_a  <= alu_data;
        if (alu_load_B)  m_b  <= alu_data;
        if (alu_load_Op) m_op <= alu_data[1:0];
        if (alu_update_Res) {alu_Flags, alu_Result} <= alu_fn(m_a, m_b, m_op);
    end

    // ---------------- helpers ----------------
    wire [3:0] strobes = {alu_load_A, alu_load_B, alu_load_Op, alu_update_Res};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic all_quiet(input string tag);
        chk({tag, "_ready"},   {30'd0, req0_ready, req1_ready}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
        chk({tag, "_strobes"}, {28'd0, strobes}, 32'd0);
        chk({tag, "_data"},    {16'd0, alu_data}, 32'd0);
        chk({tag, "_rvalid"},  {31'd0, resp_valid}, 32'd0);
        chk({tag, "_rresult"}, {16'd0, resp_Result}, 32'd0);
        chk({tag, "_dropped"}, {31'd0, resp_dropped}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Grant requester 0 with resp_ready low and stop right after the edge
    // into RESP (cycle 5).
    task automatic enter_resp(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] op);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_A = a; req0_B = b; req0_Op = op;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         v0, v1;
        logic [W-1:0] a0, b0, a1, b1;
        logic [1:0]   op0, op1;
        logic         exp_id;
        logic [W-1:0] exp_res;
        logic [3:0]   exp_flg;
    } vec_t;

    // Full transaction: cycle 0 accept, cycles 1-4 ALU loads, cycle 5 RESP,
    // cycle 6 back in IDLE. Requester inputs are scrambled and re-asserted
    // while the operation is in flight.
    task automatic run_vec(input vec_t v, input string tag);
        logic [W-1:0] wa, wb;
        logic [1:0]   wop;
        wa  = v.exp_id ? v.a1  : v.a0;
        wb  = v.exp_id ? v.b1  : v.b0;
        wop = v.exp_id ? v.op1 : v.op0;
        @(posedge clk); #1;
        req0_valid = v.v0; req1_valid = v.v1;
        req0_A = v.a0; req0_B = v.b0; req0_Op = v.op0;
        req1_A = v.a1; req1_B = v.b1; req1_Op = v.op1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_c0_ready"}, {30'd0, req1_ready, req0_ready},
            v.exp_id ? 32'd2 : 32'd1);
        chk({tag, "_c0_busy"}, {31'd0, busy}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c < 5) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
                req0_A = 16'hDEAD ^ 16'(c); req0_B = 16'hBEEF; req0_Op = 2'b11;
                req1_A = 16'hCAFE;          req1_B = 16'h0F0F; req1_Op = 2'b10;
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_nordy"}, {30'd0, req0_ready, req1_ready}, 32'd0);
            case (c)
                1: begin
                    chk({tag, "_c1_data"}, {16'd0, alu_data}, {16'd0, wa});
                    chk({tag, "_c1_strb"}, {28'd0, strobes}, 32'h8);
                    chk({tag, "_c1_busy"}, {31'd0, busy}, 32'd1);
                end
                2: begin
                    chk({tag, "_c2_data"}, {16'd0, alu_data}, {16'd0, wb});
                    chk({tag, "_c2_strb"}, {28'd0, strobes}, 32'h4);
                end
                3: begin
                    chk({tag, "_c3_data"}, {16'd0, alu_data}, {30'd0, wop});
                    chk({tag, "_c3_strb"}, {28'd0, strobes}, 32'h2);
                end
                4: begin
                    chk({tag, "_c4_data"}, {16'd0, alu_data}, 32'd0);
                    chk({tag, "_c4_strb"}, {28'd0, strobes}, 32'h1);
                    chk({tag, "_c4_rv"},   {31'd0, resp_valid}, 32'd0);
                end
                default: begin
                    chk({tag, "_c5_rv"},   {31'd0, resp_valid}, 32'd1);
                    chk({tag, "_c5_id"},   {31'd0, resp_id}, {31'd0, v.exp_id});
                    chk({tag, "_c5_res"},  {16'd0, resp_Result}, {16'd0, v.exp_res});
                    chk({tag, "_c5_flg"},  {28'd0, resp_Flags}, {28'd0, v.exp_flg});
                    chk({tag, "_c5_strb"}, {28'd0, strobes}, 32'd0);
                    chk({tag, "_c5_data"}, {16'd0, alu_data}, 32'd0);
                end
            endcase
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_c6_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_c6_rv"},   {31'd0, resp_valid}, 32'd0);
    endtask

    vec_t        vecs[7];
    vec_t        v_after_rst;
    logic [1:0]  grants[4];
    int          ng;
    logic        dual;
    int          rc;
    logic        bad;

    initial begin
        //        v0    v1    a0        b0        a1        b1        op0    op1    id    res       flags
        vecs[0] = '{1'b1, 1'b0, 16'h0005, 16'h0003, 16'h1111, 16'h2222, 2'b00, 2'b01, 1'b0, 16'h0008, 4'b0000};
        vecs[1] = '{1'b1, 1'b1, 16'h00AA, 16'h0055, 16'h0003, 16'h0005, 2'b11, 2'b01, 1'b1, 16'hFFFE, 4'b1010};
        vecs[2] = '{1'b1, 1'b0, 16'h00F0, 16'h0F0F, 16'h0000, 16'h0000, 2'b10, 2'b00, 1'b0, 16'h0000, 4'b0100};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 16'h0000, 4'b0110};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h0001, 2'b00, 2'b11, 1'b1, 16'h8001, 4'b1000};
        vecs[5] = '{1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'h0F0F, 16'h00FF, 2'b00, 2'b10, 1'b0, 16'h8000, 4'b1001};
        vecs[6] = '{1'b1, 1'b1, 16'h1234, 16'h4321, 16'h8000, 16'h0001, 2'b00, 2'b01, 1'b1, 16'h7FFF, 4'b0001};
        v_after_rst = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0006, 16'h0002, 2'b00, 2'b01, 1'b1, 16'h0004, 4'b0000};

        // Reset with requests pending: nothing may be accepted.
        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_A = 16'h0000; req0_B = 16'h0000; req0_Op = 2'b00;
        req1_A = 16'h0000; req1_B = 16'h0000; req1_Op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        all_quiet("in_rst");
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        all_quiet("post_rst");

        // Table: latency, strobes, arbitration and ALU flag cases.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Response held for 10 cycles with resp_ready low.
        enter_resp(16'h0010, 16'h0020, 2'b00);
        for (int k = 0; k < 10; k++) begin
            req0_valid = 1'b1;
            @(negedge clk);
            chk("hold_rv",    {31'd0, resp_valid}, 32'd1);
            chk("hold_res",   {16'd0, resp_Result}, 32'h0030);
            chk("hold_rdy",   {30'd0, req0_ready, req1_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_last_rv", {31'd0, resp_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_exit_busy", {31'd0, busy}, 32'd0);
        chk("hold_exit_rv",   {31'd0, resp_valid}, 32'd0);

        // Reset in the middle of LOAD_B discards the operation.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_A = 16'h0009; req0_B = 16'h0004; req0_Op = 2'b00;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_lb_busy", {31'd0, busy}, 32'd0);
        chk("rst_lb_strb", {28'd0, strobes}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        all_quiet("rst_lb_after");
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid || busy || (strobes != 4'b0000)) bad = 1'b1;
        end
        chk("rst_lb_no_resp", {31'd0, bad}, 32'd0);
        run_vec(v_after_rst, "rst_req1");

        // Both requesters valid continuously: grants must alternate 0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_A = 16'h0001; req0_B = 16'h0001; req0_Op = 2'b00;
        req1_A = 16'h0002; req1_B = 16'h0002; req1_Op = 2'b00;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) grants[i] = 2'b11;
        ng = 0; dual = 1'b0;
        for (int k = 0; k < 80 && ng < 4; k++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) dual = 1'b1;
            if (req0_ready || req1_ready) begin
                grants[ng] = {1'b0, req1_ready};
                ng++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", ng, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), {30'd0, grants[i]}, 32'(i % 2));
        end
        chk("rr_dual_ready", {31'd0, dual}, 32'd0);
        wait_idle("rr");

`ifdef ALU_ARB_TIMEOUT_EN
        // Unaccepted response is dropped after 16 RESP cycles.
        enter_resp(16'h0001, 16'h0001, 2'b00);
        rc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!resp_valid) break;
            rc++;
            @(posedge clk); #1;
        end
        chk("to_resp_cycles", rc, 32'd16);
        chk("to_busy",        {31'd0, busy}, 32'd0);
        chk("to_dropped",     {31'd0, resp_dropped}, 32'd1);
        repeat (5) @(negedge clk);
        chk("to_sticky", {31'd0, resp_dropped}, 32'd1);
        run_vec(vecs[0], "to_next");
        chk("to_sticky2", {31'd0, resp_dropped}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("to_cleared", {31'd0, resp_dropped}, 32'd0);
`else
        // Without the timeout the response waits indefinitely.
        enter_resp(16'h0001, 16'h0001, 2'b00);
        rc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid) rc++;
            @(posedge clk); #1;
        end
        chk("wait_resp_cycles", rc, 32'd20);
        chk("wait_dropped",     {31'd0, resp_dropped}, 32'd0);
        chk("wait_res",         {16'd0, resp_Result}, 32'h0002);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_exit_busy", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N holds a pending operation.
REQ-005 SHALL have ports req0_A, req0_B, req1_A and req1_B, input, WIDTH bits each: operands.
REQ-006 SHALL have ports req0_Op and req1_Op, input, 2 bits each: ALU opcode.
REQ-007 SHALL have ports req0_ready and req1_ready, output, 1 bit each: one-cycle accept pulse.
REQ-008 SHALL have port alu_data, output, WIDTH bits: shared operand/opcode bus to reg_ALU i_A, i_B and i_OpCode (bits [1:0]).
REQ-009 SHALL have ports alu_load_A, alu_load_B, alu_load_Op and alu_update_Res, output, 1 bit each: reg_ALU strobes.
REQ-010 SHALL have ports alu_Result (WIDTH bits) and alu_Flags (4 bits), input: reg_ALU outputs.
REQ-011 SHALL have ports resp_valid (1 bit), resp_id (1 bit), resp_Result (WIDTH bits) and resp_Flags (4 bits), output: response to the granted requester.
REQ-012 SHALL have port resp_ready, input, 1 bit: consumer accepts the response.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port resp_dropped, output, 1 bit: sticky timeout indicator (see Configuration).

Function
REQ-015 SHALL implement the FSM IDLE -> LOAD_A -> LOAD_B -> LOAD_OP -> EXEC -> RESP -> IDLE; every transition except those out of IDLE and RESP SHALL be unconditional.
REQ-016 In IDLE with any reqN_valid high, SHALL grant one requester, pulse its reqN_ready for exactly that cycle, latch its A, B and Op into internal registers along with the grant id, and go to LOAD_A.
REQ-017 SHALL arbitrate round-robin: when only one requester is valid, that requester wins; when both are valid, the one not granted last wins; the last-grant pointer updates only on grant.
REQ-018 SHALL never assert both ready signals in the same cycle, and SHALL assert no ready signal outside IDLE.
REQ-019 LOAD_A SHALL drive alu_data = latched A with alu_load_A=1.
REQ-020 LOAD_B SHALL drive alu_data = latched B with alu_load_B=1.
REQ-021 LOAD_OP SHALL drive alu_data = {WIDTH-2 zeros, Op} with alu_load_Op=1.
REQ-022 EXEC SHALL drive alu_update_Res=1.
REQ-023 At most one ALU strobe SHALL be high in any cycle; alu_data SHALL be 0 in IDLE, EXEC and RESP.
REQ-024 In RESP, SHALL assert resp_valid=1 with resp_id = grant id, and SHALL drive resp_Result/resp_Flags directly from alu_Result/alu_Flags.
REQ-025 In RESP, SHALL hold all response outputs stable until resp_ready=1, then return to IDLE in the next cycle.
REQ-026 Latency SHALL be fixed: resp_valid rises 5 cycles after the ready pulse (accept cycle 0, RESP in cycle 5).
REQ-027 A request arriving, or requester inputs changing, after accept SHALL NOT affect the operation in flight.
REQ-028 A requester that drops valid while not granted SHALL lose nothing; no request is queued internally.
REQ-029 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-030 On reset=1 at a clock edge, SHALL go to IDLE from any state, including mid-operation, discarding the in-flight operation with no response.
REQ-031 On reset, SHALL set the last-grant pointer so requester 0 wins the first tie.
REQ-032 On reset, SHALL clear all latched operands and clear resp_dropped.
REQ-033 During and after reset, all outputs SHALL be 0 until the next grant.

Configuration
REQ-034 With macro ALU_ARB_TIMEOUT_EN defined, SHALL count RESP cycles with resp_ready=0; on the 16th such cycle, SHALL drop the response, set resp_dropped=1 (sticky until reset) and return to IDLE.
REQ-035 Without ALU_ARB_TIMEOUT_EN, RESP SHALL wait indefinitely and resp_dropped SHALL be tied to 0.

Verification
REQ-036 Reset, then req0 A=0x0005, B=0x0003, Op=2'b00 -> req0_ready in cycle 0; alu_data=0x0005/0x0003/0x0000 with the matching strobe in cycles 1-3; update_Res in cycle 4; resp_valid, resp_id=0 and resp_Result=reg_ALU model value in cycle 5.
REQ-037 Both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 over four operations; never two readies in one cycle.
REQ-038 resp_ready held 0 for 10 cycles in RESP -> resp_valid and resp_Result stable throughout; IDLE the cycle after resp_ready=1.
REQ-039 reset=1 asserted in LOAD_B -> next cycle busy=0, all strobes 0, no resp_valid; a new req1 is then granted normally.
REQ-040 With ALU_ARB_TIMEOUT_EN defined, resp_ready=0 for 20 cycles -> return to IDLE after 16 RESP cycles with resp_dropped=1; resp_dropped stays 1 until reset.
